ch_buf_rd_ctrl: RTL and testbench
=================================

# ch_buf_rd_ctrl

Read-side controller for the receive channel buffer, a 200-entry circular carrier store written once per used carrier. Tracks buffer occupancy from the write strobes and drives the buffer read address and start pulse. Streams buffered carriers to the channel estimator and equalizer over a valid/ready handshake, tagging symbol boundaries and long-training symbols. Sits between the FFT-side buffer and the estimator/equalizer in the OFDM receive chain.

## Interface
- N_CAR, 200, used carriers per OFDM symbol; equals buffer depth
- N_LTS, 2, long-training symbols at the start of each frame
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse marking a new frame
- frame_end  in  1  one-cycle pulse: no further writes in this frame
- buf_wr  in  1  a carrier was written to the buffer this cycle (ena & car_val & ~full)
- buf_dat  in  32  buffer read data; combinational from rd_addr
- buf_start  out  1  combinational copy of frame_start; resets the buffer write pointer
- rd_addr  out  8  buffer read address, 0..N_CAR-1
- dout  out  32  carrier sample (I/Q 16/16)
- dout_car  out  8  carrier index of dout, 0..N_CAR-1
- dout_sof  out  1  dout is carrier 0 of a symbol
- dout_lts  out  1  dout belongs to a training symbol
- dout_val  out  1  dout valid
- dout_rdy  in  1  downstream accepts dout
- busy  out  1  state is not IDLE
- ovf_err  out  1  sticky overflow flag (see Configuration)

## Operation
- States: IDLE, LTS, DATA.
- IDLE -> LTS on frame_start, from any state. On frame_start: rd_addr, occ, car_idx, sym_cnt and the frame_end latch clear; dout_val clears, dropping any pending word.
- occ (0..N_CAR): +1 on buf_wr, -1 on read issue, both in the same cycle -> unchanged. buf_wr is ignored in IDLE and in the frame_start cycle.
- Read issue: state != IDLE, occ > 0, and (!dout_val | dout_rdy). On issue:
  - dout <= buf_dat; dout_car <= car_idx
  - dout_sof <= (car_idx == 0); dout_lts <= (sym_cnt < N_LTS)
  - rd_addr and car_idx advance, wrapping N_CAR-1 -> 0
  - sym_cnt increments when car_idx wraps; saturates at 255
- LTS -> DATA on issue of carrier N_CAR-1 of symbol N_LTS-1.
- frame_end is latched. LTS/DATA -> IDLE when the latch is set, occ == 0 and dout_val == 0.
- Handshake: dout_val holds with dout stable until dout_rdy. Transfer occurs when dout_val & dout_rdy. Back-to-back transfers run at one per cycle.
- Reset values: rd_addr 0, dout 0, dout_car 0, dout_sof 0, dout_lts 0, dout_val 0, busy 0, ovf_err 0, state IDLE.

## Timing
- buf_wr in cycle t -> read issued at cycle t+1 at the earliest -> dout_val high in cycle t+2.
- rd_addr is registered. buf_dat is sampled in the cycle the read is issued.
- buf_start has zero latency from frame_start.
- busy is high from the cycle after frame_start until the cycle after the IDLE transition.
- rst takes priority over frame_start, and frame_start over all other events. A reset mid-frame returns every output to its reset value on the next edge.

## Configuration
- CH_BUF_CTRL_OVF_EN defined:
  - ovf_err is set when buf_wr arrives with occ == N_CAR and no read is issued in that cycle; occ saturates at N_CAR.
  - ovf_err clears only on rst or frame_start.
- CH_BUF_CTRL_OVF_EN undefined: ovf_err is tied to 0 and the detection logic is omitted.

## Test plan
- Reset, then frame_start, then 600 consecutive buf_wr with dout_rdy=1:
  - 600 outputs with dout_car cycling 0..199 three times
  - dout_sof on each carrier 0
  - dout_lts=1 for the first 400 outputs, 0 for the rest
  - first dout_val two cycles after the first buf_wr
- dout_rdy held 0 for 10 cycles mid-stream with writes continuing: dout stays stable, occ rises by 10, then drains at one transfer per cycle with no loss or reordering.
- Read address wrap: after carrier 199, rd_addr returns to 0; buf_dat at address 0 is output with dout_car=0 and dout_sof=1.
- frame_end with occ=5: exactly 5 more transfers, then busy falls; buf_wr in IDLE leaves occ=0.
- frame_start while dout_val=1 and occ=50: in the next cycle dout_val=0, rd_addr=0, state LTS; the old data is never output.
- With CH_BUF_CTRL_OVF_EN, dout_rdy=0 and 202 writes: ovf_err=1 after write 202 (buffer holds 200 and the output register 1) and stays set until frame_start. Without the macro, ovf_err stays 0.

Source files
------------

// File: rtl/ch_buf_rd_ctrl_if.sv
// Output stream from the channel-buffer read controller to the estimator/equalizer.
// A word moves when dout_val & dout_rdy at a clock edge; while dout_val is high and
// dout_rdy is low, dout and its tags hold steady; dout_val never waits on dout_rdy.
interface ch_buf_rd_ctrl_if;
  logic [31:0] dout;
  logic [7:0]  dout_car;
  logic        dout_sof;
  logic        dout_lts;
  logic        dout_val;
  logic        dout_rdy;

  modport master (output dout, output dout_car, output dout_sof, output dout_lts,
                  output dout_val, input dout_rdy);
  modport slave  (input dout, input dout_car, input dout_sof, input dout_lts,
                  input dout_val, output dout_rdy);
endinterface

// File: rtl/ch_buf_rd_ctrl.sv
// Read-side controller for the 200-entry receive channel buffer: tracks occupancy and
// streams carriers with symbol/training tags. Optional overflow flag: CH_BUF_CTRL_OVF_EN.
module ch_buf_rd_ctrl #(
    parameter int N_CAR = 200,
    parameter int N_LTS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    frame_end,
    input  logic                    buf_wr,
    input  logic [31:0]             buf_dat,
    output logic                    buf_start,
    output logic [7:0]              rd_addr,
    ch_buf_rd_ctrl_if.master        dout_if,
    output logic                    busy,
    output logic                    ovf_err,
    output logic [1:0]              dbg_state,
    output logic [7:0]              dbg_occ
);

    typedef enum logic [1:0] {IDLE = 2'd0, LTS = 2'd1, DATA = 2'd2} state_t;

    localparam logic [7:0] LAST_CAR = 8'(N_CAR - 1);
    localparam logic [7:0] OCC_MAX  = 8'(N_CAR);
    localparam logic [7:0] LAST_LTS = 8'(N_LTS - 1);
    localparam logic [7:0] NUM_LTS  = 8'(N_LTS);

    state_t     state_q, state_d;
    logic [7:0] occ_q;
    logic [7:0] sym_cnt_q;
    logic       fe_q;
    logic       wr_en, issue, car_wrap, occ_full, drained;

    // The carrier index always equals the read address, so rd_addr serves as car_idx.
    always_comb begin
        wr_en    = buf_wr && (state_q != IDLE);
        issue    = (state_q != IDLE) && (occ_q != 8'd0) &&
                   (!dout_if.dout_val || dout_if.dout_rdy);
        car_wrap = (rd_addr == LAST_CAR);
        occ_full = (occ_q == OCC_MAX);
        drained  = fe_q && (occ_q == 8'd0) && !dout_if.dout_val;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LTS: begin
                if (issue && car_wrap && (sym_cnt_q == LAST_LTS)) state_d = DATA;
                else if (drained)                                state_d = IDLE;
            end
            DATA:    if (drained) state_d = IDLE;
            default: state_d = state_q;
        endcase
        if (frame_start) state_d = LTS;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            occ_q            <= 8'd0;
            sym_cnt_q        <= 8'd0;
            fe_q             <= 1'b0;
            rd_addr          <= 8'd0;
            dout_if.dout     <= 32'd0;
            dout_if.dout_car <= 8'd0;
            dout_if.dout_sof <= 1'b0;
            dout_if.dout_lts <= 1'b0;
            dout_if.dout_val <= 1'b0;
        end else if (frame_start) begin
            // A new frame discards everything buffered, including a word waiting on dout_rdy.
            state_q          <= state_d;
            occ_q            <= 8'd0;
            sym_cnt_q        <= 8'd0;
            fe_q             <= 1'b0;
            rd_addr          <= 8'd0;
            dout_if.dout_val <= 1'b0;
        end else begin
            state_q <= state_d;
            if (frame_end) fe_q <= 1'b1;

            case ({wr_en, issue})
                2'b10:   if (!occ_full) occ_q <= occ_q + 8'd1;
                2'b01:   occ_q <= occ_q - 8'd1;
                default: occ_q <= occ_q;
            endcase

            if (issue) begin
                dout_if.dout     <= buf_dat;
                dout_if.dout_car <= rd_addr;
                dout_if.dout_sof <= (rd_addr == 8'd0);
                dout_if.dout_lts <= (sym_cnt_q < NUM_LTS);
                dout_if.dout_val <= 1'b1;
                rd_addr          <= car_wrap ? 8'd0 : rd_addr + 8'd1;
                if (car_wrap && (sym_cnt_q != 8'hFF)) sym_cnt_q <= sym_cnt_q + 8'd1;
            end else if (dout_if.dout_rdy) begin
                dout_if.dout_val <= 1'b0;
            end
        end
    end

`ifdef CH_BUF_CTRL_OVF_EN
    logic ovf_q;

    // A write into a full buffer with no read to make room is lost; flag it until the next frame.
    always_ff @(posedge clk) begin
        if (rst || frame_start)                ovf_q <= 1'b0;
        else if (wr_en && occ_full && !issue)  ovf_q <= 1'b1;
    end

    assign ovf_err = ovf_q;
`else
    assign ovf_err = 1'b0;
`endif

    assign buf_start = frame_start;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;
    assign dbg_occ   = occ_q;

endmodule

// File: tb/tb_ch_buf_rd_ctrl.sv
// Directed bench for ch_buf_rd_ctrl: a behavioural buffer feeds the DUT, a scoreboard queue
// holds expected words pushed at write time, and a monitor pops them on each transfer.
`timescale 1ns/1ps
module tb_ch_buf_rd_ctrl;
  localparam int N_CAR = 200;
  localparam int W     = 42;
`ifdef CH_BUF_CTRL_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        buf_wr = 1'b0;
  logic [31:0] buf_dat;
  logic [31:0] wdat = 32'd0;
  logic        buf_start;
  logic [7:0]  rd_addr;
  logic        busy;
  logic        ovf_err;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_occ;

  ch_buf_rd_ctrl_if dif ();

  ch_buf_rd_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .buf_wr      (buf_wr),
    .buf_dat     (buf_dat),
    .buf_start   (buf_start),
    .rd_addr     (rd_addr),
    .dout_if     (dif),
    .busy        (busy),
    .ovf_err     (ovf_err),
    .dbg_state   (dbg_state),
    .dbg_occ     (dbg_occ)
  );

  // clock / buffer model
  always #5 clk = ~clk;

  logic [31:0] mem [0:N_CAR-1];
  int wp = 0;
  always @(posedge clk) begin
    if (buf_start) wp <= 0;
    else if (buf_wr) begin
      mem[wp] <= wdat;
      wp <= (wp == N_CAR - 1) ? 0 : wp + 1;
    end
  end
  assign buf_dat = mem[rd_addr];

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int n_xfer   = 0;
  int wr_cnt   = 0;
  int seq      = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input bit expect_out);
    logic [7:0] car;
    logic       sof, lts;
    wdat   = {16'(seq) ^ 16'hA5A5, 16'h1000 + 16'(seq)};
    seq++;
    buf_wr = 1'b1;
    if (expect_out) begin
      car = 8'(wr_cnt % N_CAR);
      sof = (car == 8'd0);
      lts = (wr_cnt < 2 * N_CAR);
      exp_q.push_back({wdat, car, sof, lts});
      wr_cnt++;
    end
  endtask

  task automatic write_n(input int n, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      drive_wr(expect_out);
      tick();
    end
    buf_wr = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    exp_q.delete();
    wr_cnt = 0;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int k = 0; k < limit && exp_q.size() != 0; k++) tick();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // monitor
  logic [W-1:0] cur;
  logic [W-1:0] hold_word;
  bit           hold = 1'b0;
  always @(negedge clk) begin
    cur = {dif.dout, dif.dout_car, dif.dout_sof, dif.dout_lts};
    if (!rst) begin
      if (hold && dif.dout_val) check("hold_stable", 64'(cur), 64'(hold_word));
      if (dif.dout_val && dif.dout_car == 8'd199) check("rd_addr_wrap", 64'(rd_addr), 64'd0);
      if (dif.dout_val && dif.dout_rdy) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_xfer: got %0h expected no transfer", cur);
        end else begin
          check("xfer", 64'(cur), 64'(exp_q.pop_front()));
        end
      end
    end
    hold      = dif.dout_val && !dif.dout_rdy;
    hold_word = cur;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int occ0, occ1, xfer0;
    dif.dout_rdy = 1'b1;

    // reset values
    rst = 1'b1;
    repeat (3) tick();
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_dout", 64'(dif.dout), 64'd0);
    check("rst_dout_car", 64'(dif.dout_car), 64'd0);
    check("rst_dout_sof", 64'(dif.dout_sof), 64'd0);
    check("rst_dout_lts", 64'(dif.dout_lts), 64'd0);
    check("rst_dout_val", 64'(dif.dout_val), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(ovf_err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    tick();

    // frame start: buf_start is immediate, busy follows one cycle later
    frame_start = 1'b1;
    exp_q.delete();
    wr_cnt = 0;
    #1;
    check("buf_start_comb", 64'(buf_start), 64'd1);
    tick();
    frame_start = 1'b0;
    #1;
    check("buf_start_low", 64'(buf_start), 64'd0);
    check("fs_busy", 64'(busy), 64'd1);
    check("fs_state_lts", 64'(dbg_state), 64'd1);

    // 600 back-to-back writes, three symbols
    for (int i = 0; i < 600; i++) begin
      drive_wr(1'b1);
      tick();
      if (i == 0) check("first_val_t1", 64'(dif.dout_val), 64'd0);
      if (i == 1) check("first_val_t2", 64'(dif.dout_val), 64'd1);
    end
    buf_wr = 1'b0;
    wait_drain("stream_drain", 20);
    check("stream_count", 64'(n_xfer), 64'd600);
    check("state_data", 64'(dbg_state), 64'd2);

    // 10-cycle stall with writes continuing, then drain at one per cycle
    write_n(5, 1'b1);
    buf_wr = 1'b1;
    dif.dout_rdy = 1'b0;
    occ0 = int'(dbg_occ);
    for (int i = 0; i < 10; i++) begin
      drive_wr(1'b1);
      tick();
    end
    buf_wr = 1'b0;
    check("stall_occ", 64'(dbg_occ), 64'(occ0 + 10));
    dif.dout_rdy = 1'b1;
    occ1 = int'(dbg_occ);
    repeat (occ1 + 1) tick();
    check("drain_rate", 64'(exp_q.size()), 64'd0);

    // frame_end with five buffered plus one held in the output register
    dif.dout_rdy = 1'b0;
    write_n(6, 1'b1);
    check("fe_occ", 64'(dbg_occ), 64'd5);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    xfer0 = n_xfer;
    dif.dout_rdy = 1'b1;
    for (int k = 0; k < 50 && busy; k++) tick();
    check("fe_idle", 64'(busy), 64'd0);
    check("fe_xfers", 64'(n_xfer - xfer0), 64'd6);
    check("fe_queue", 64'(exp_q.size()), 64'd0);

    // writes while idle are ignored
    write_n(3, 1'b0);
    tick();
    check("idle_occ", 64'(dbg_occ), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_val", 64'(dif.dout_val), 64'd0);

    // frame_start with a pending word and occ=50 drops everything
    pulse_fs();
    dif.dout_rdy = 1'b0;
    write_n(51, 1'b1);
    check("pre_fs_occ", 64'(dbg_occ), 64'd50);
    check("pre_fs_val", 64'(dif.dout_val), 64'd1);
    frame_start = 1'b1;
    drive_wr(1'b0);
    exp_q.delete();
    wr_cnt = 0;
    tick();
    frame_start = 1'b0;
    buf_wr = 1'b0;
    check("fs_flush_val", 64'(dif.dout_val), 64'd0);
    check("fs_flush_addr", 64'(rd_addr), 64'd0);
    check("fs_flush_state", 64'(dbg_state), 64'd1);
    check("fs_flush_occ", 64'(dbg_occ), 64'd0);
    dif.dout_rdy = 1'b1;
    write_n(3, 1'b1);
    wait_drain("new_frame_drain", 20);

    // overflow: 200 buffered + 1 held, then one more write
    pulse_fs();
    dif.dout_rdy = 1'b0;
    write_n(201, 1'b1);
    check("ovf_pre", 64'(ovf_err), 64'd0);
    check("ovf_pre_occ", 64'(dbg_occ), 64'd200);
    write_n(1, 1'b0);
    check("ovf_set", 64'(ovf_err), 64'(OVF_EXP));
    check("ovf_occ_sat", 64'(dbg_occ), 64'd200);
    repeat (3) tick();
    check("ovf_sticky", 64'(ovf_err), 64'(OVF_EXP));
    pulse_fs();
    check("ovf_clear", 64'(ovf_err), 64'd0);
    check("ovf_clear_occ", 64'(dbg_occ), 64'd0);
    dif.dout_rdy = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
